// File: rtl/spi_register_bank.sv
// SPI target with a flat register file, oversampled in the sys_clock_i domain.
// Pad inputs are synchronised, edges are turned into one-cycle pulses, and a
// small IDLE/CMD/DATA FSM decodes the command byte followed by data words.
module spi_register_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int SPI_MODE   = 0
) (
  input  logic                              sys_clock_i,
  input  logic                              sys_reset_ni,
  input  logic                              spi_clock_i,
  input  logic                              spi_cs_i,
  input  logic                              spi_pico_i,
  output logic                              spi_poci_o,
  output logic                              spi_poci_oe_o,
  input  logic                              local_we_i,
  input  logic [ADDR_WIDTH-1:0]             local_addr_i,
  input  logic [DATA_WIDTH-1:0]             local_data_i,
  output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] regs_o,
  output logic                              spi_write_strobe_o,
  output logic [ADDR_WIDTH-1:0]             spi_write_addr_o
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam bit CPOL = ((SPI_MODE / 2) % 2) == 1;
  localparam bit CPHA = (SPI_MODE % 2) == 1;
  // Sample on the rising edge when CPOL == CPHA, otherwise on the falling edge
  localparam bit SAMPLE_ON_RISE = (CPOL == CPHA);
  localparam logic [5:0] LAST_BIT = 6'(DATA_WIDTH - 1);
  localparam logic [5:0] CMD_LAST = 6'd7;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

  logic [2:0]            sclk_sync_q, cs_sync_q, pico_sync_q;
  logic                  sclk_rise_q, sclk_fall_q, cs_fall_q, cs_rise_q;
  logic                  oe_q;
  state_e                state_q, state_d;
  logic [5:0]            bitcnt_q, bitcnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [DATA_WIDTH-2:0] shin_q, shin_d;
  logic [DATA_WIDTH-1:0] shout_q, shout_d;
  logic                  poci_q, poci_d;
  logic                  strobe_q, strobe_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  logic                  sample_edge, shift_edge;
  logic [DATA_WIDTH-1:0] word_in;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  assign sample_edge = SAMPLE_ON_RISE ? sclk_rise_q : sclk_fall_q;
  assign shift_edge  = SAMPLE_ON_RISE ? sclk_fall_q : sclk_rise_q;
  assign word_in     = {shin_q, pico_sync_q[2]};
  assign addr_nxt    = addr_q + 1'b1;

  // Synchronise the pads, register edge pulses and the pad output enable.
  // CS resets to deasserted so leaving reset never fakes a CS falling edge.
  always_ff @(posedge sys_clock_i or negedge sys_reset_ni) begin
    if (!sys_reset_ni) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      pico_sync_q <= 3'b000;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi_clock_i};
      cs_sync_q   <= {cs_sync_q[1:0], spi_cs_i};
      pico_sync_q <= {pico_sync_q[1:0], spi_pico_i};
      sclk_rise_q <= sclk_sync_q[1] & ~sclk_sync_q[2];
      sclk_fall_q <= ~sclk_sync_q[1] & sclk_sync_q[2];
      cs_fall_q   <= ~cs_sync_q[1] & cs_sync_q[2];
      cs_rise_q   <= cs_sync_q[1] & ~cs_sync_q[2];
      oe_q        <= ~cs_sync_q[2];
    end
  end

  // Transaction FSM and shift datapath next-state logic.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    shin_d   = shin_q;
    shout_d  = shout_q;
    poci_d   = poci_q;
    strobe_d = 1'b0;
    waddr_d  = waddr_q;
    case (state_q)
      IDLE: begin
        poci_d = 1'b0;
        if (cs_fall_q) begin
          state_d  = CMD;
          bitcnt_d = '0;
        end
      end
      CMD: begin
        poci_d = 1'b0;
        if (sample_edge) begin
          shin_d   = word_in[DATA_WIDTH-2:0];
          bitcnt_d = bitcnt_q + 6'd1;
          if (bitcnt_q == CMD_LAST) begin
            // word_in[7] is the R/W bit; upper address bits are dropped
            state_d  = DATA;
            bitcnt_d = '0;
            rw_d     = word_in[7];
            addr_d   = word_in[ADDR_WIDTH-1:0];
            if (!word_in[7]) shout_d = regs_q[word_in[ADDR_WIDTH-1:0]];
          end
        end
      end
      DATA: begin
        if (rw_q) begin
          poci_d = 1'b0;
        end else if (shift_edge) begin
          poci_d  = shout_q[DATA_WIDTH-1];
          shout_d = shout_q << 1;
        end
        if (sample_edge) begin
          shin_d   = word_in[DATA_WIDTH-2:0];
          bitcnt_d = bitcnt_q + 6'd1;
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d = '0;
            addr_d   = addr_nxt;
            if (rw_q) begin
              strobe_d = 1'b1;
              waddr_d  = addr_q;
            end else begin
              shout_d = regs_q[addr_nxt];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // CS release aborts whatever is in progress; partial words never commit
    if (cs_rise_q) begin
      state_d  = IDLE;
      poci_d   = 1'b0;
      strobe_d = 1'b0;
    end
  end

  // Register file update: SPI commit overrides a local write to the same entry.
  always_comb begin
    regs_d = regs_q;
    if (local_we_i) regs_d[local_addr_i] = local_data_i;
    if (strobe_d)   regs_d[addr_q] = word_in;
  end

  // State, datapath and register file storage.
  always_ff @(posedge sys_clock_i or negedge sys_reset_ni) begin
    if (!sys_reset_ni) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      shin_q   <= '0;
      shout_q  <= '0;
      poci_q   <= 1'b0;
      strobe_q <= 1'b0;
      waddr_q  <= '0;
      for (int n = 0; n < DEPTH; n++) regs_q[n] <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      shin_q   <= shin_d;
      shout_q  <= shout_d;
      poci_q   <= poci_d;
      strobe_q <= strobe_d;
      waddr_q  <= waddr_d;
      regs_q   <= regs_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign spi_poci_o         = poci_q;
  assign spi_poci_oe_o      = oe_q;
  assign spi_write_strobe_o = strobe_q;
  assign spi_write_addr_o   = waddr_q;

endmodule

// File: tb/tb_spi_register_bank.sv
// Bench for spi_register_bank: four DW=8/AW=4 instances (modes 0-3) and one
// DW=16/AW=2 instance share the pads; only the selected instance sees CS.
module tb_spi_register_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cs_b, sclk_lvl, pico_b;
  int          cur;
  logic        lwe;
  logic [3:0]  laddr;
  logic [15:0] ldata;

  logic [127:0] regs8  [4];
  logic         strobe8[4];
  logic [3:0]   waddr8 [4];
  logic         poci8  [4];
  logic         oe8    [4];
  logic [63:0]  regs16;
  logic         strobe16, poci16, oe16;
  logic [1:0]   waddr16;

  for (genvar g = 0; g < 4; g++) begin : g_m
    localparam logic CP = (g >= 2);
    spi_register_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .SPI_MODE(g)) u_dut (
      .sys_clock_i(clk), .sys_reset_ni(rst_n),
      .spi_clock_i((cur == g) ? (sclk_lvl ^ CP) : CP),
      .spi_cs_i((cur == g) ? cs_b : 1'b1),
      .spi_pico_i(pico_b),
      .spi_poci_o(poci8[g]), .spi_poci_oe_o(oe8[g]),
      .local_we_i(lwe && (cur == g)), .local_addr_i(laddr), .local_data_i(ldata[7:0]),
      .regs_o(regs8[g]), .spi_write_strobe_o(strobe8[g]), .spi_write_addr_o(waddr8[g]));
  end

  spi_register_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .SPI_MODE(0)) u_dut16 (
    .sys_clock_i(clk), .sys_reset_ni(rst_n),
    .spi_clock_i((cur == 4) ? sclk_lvl : 1'b0),
    .spi_cs_i((cur == 4) ? cs_b : 1'b1),
    .spi_pico_i(pico_b),
    .spi_poci_o(poci16), .spi_poci_oe_o(oe16),
    .local_we_i(lwe && (cur == 4)), .local_addr_i(laddr[1:0]), .local_data_i(ldata),
    .regs_o(regs16), .spi_write_strobe_o(strobe16), .spi_write_addr_o(waddr16));

  typedef struct {int dut; int addr; int data;} sb_t;
  sb_t sb_q[$];

  int cmp_cnt = 0, err_cnt = 0;
  int cyc = 0, last_samp_cyc = 0, last_strobe_cyc = 0, strobe_cnt = 0;
  int lw_at_cyc = -1;
  logic lw_arm = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] get_reg(int d, int a);
    if (d < 4) return 32'(regs8[d][a*8 +: 8]);
    return 32'(regs16[a*16 +: 16]);
  endfunction

  function automatic logic get_poci(int d);
    return (d < 4) ? poci8[d] : poci16;
  endfunction

  function automatic logic get_oe(int d);
    return (d < 4) ? oe8[d] : oe16;
  endfunction

  function automatic int dw_of(int d);
    return (d < 4) ? 8 : 16;
  endfunction

  function automatic int depth_of(int d);
    return (d < 4) ? 16 : 4;
  endfunction

  // Local write driver: pulses lwe for the one cycle requested
  always @(negedge clk) begin
    if (cyc == lw_at_cyc) lwe = 1'b1;
    else lwe = 1'b0;
  end

  // Monitor: every strobe pops one expected commit
  always @(negedge clk) begin
    for (int d = 0; d < 5; d++) begin
      if ((d < 4) ? strobe8[d] : strobe16) begin
        sb_t e;
        int wa;
        strobe_cnt++;
        last_strobe_cyc = cyc;
        wa = (d < 4) ? int'(waddr8[d]) : int'(waddr16);
        if (sb_q.size() == 0) begin
          chk("unexpected_strobe", 128'(d), 128'(99));
        end else begin
          e = sb_q.pop_front();
          chk("strobe_dut", 128'(d), 128'(e.dut));
          chk("strobe_addr", 128'(wa), 128'(e.addr));
          chk("strobe_data", 128'(get_reg(d, wa)), 128'(e.data));
        end
      end
    end
  end

  task automatic sample_point(input int i, inout logic [31:0] rx);
    last_samp_cyc = cyc;
    rx = {rx[30:0], get_poci(cur)};
    if (lw_arm && i == 0) begin
      lw_at_cyc = cyc + 3;
      lw_arm = 1'b0;
    end
  endtask

  task automatic spi_word(input int n, input logic [31:0] tx, output logic [31:0] rx);
    logic [31:0] r;
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if ((cur < 4) && (cur % 2 == 1)) begin
        sclk_lvl = 1'b1; pico_b = tx[i];
        repeat (8) @(negedge clk);
        sclk_lvl = 1'b0; sample_point(i, r);
        repeat (8) @(negedge clk);
      end else begin
        pico_b = tx[i];
        repeat (8) @(negedge clk);
        sclk_lvl = 1'b1; sample_point(i, r);
        repeat (8) @(negedge clk);
        sclk_lvl = 1'b0;
      end
    end
    rx = r;
  endtask

  task automatic spi_begin();
    cs_b = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (8) @(negedge clk);
    cs_b = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic spi_write(input logic [7:0] cmd, input int nw, input logic [31:0] d0, input logic [31:0] d1);
    logic [31:0] rx;
    int a;
    a = int'(cmd[6:0]) % depth_of(cur);
    sb_q.push_back('{cur, a, int'(d0)});
    if (nw > 1) sb_q.push_back('{cur, (a + 1) % depth_of(cur), int'(d1)});
    spi_begin();
    spi_word(8, 32'(cmd), rx);
    spi_word(dw_of(cur), d0, rx);
    if (nw > 1) spi_word(dw_of(cur), d1, rx);
    spi_end();
  endtask

  task automatic spi_read(input logic [7:0] cmd, output logic [31:0] data);
    logic [31:0] rx;
    spi_begin();
    chk("oe_during_cs", 128'(get_oe(cur)), 128'(1));
    spi_word(8, 32'(cmd), rx);
    spi_word(dw_of(cur), 32'(0), data);
    spi_end();
    chk("oe_after_cs", 128'(get_oe(cur)), 128'(0));
    chk("poci_idle", 128'(get_poci(cur)), 128'(0));
  endtask

  logic [31:0] rd, tmp;
  int s0;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; cs_b = 1'b1; sclk_lvl = 1'b0; pico_b = 1'b0; cur = 0;
    laddr = '0; ldata = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_regs", regs8[0], 128'(0));
    chk("rst_strobe", 128'(strobe8[0]), 128'(0));
    chk("rst_waddr", 128'(waddr8[0]), 128'(0));
    chk("rst_poci", 128'(poci8[0]), 128'(0));
    chk("rst_oe", 128'(oe8[0]), 128'(0));
    chk("rst_regs16", 128'(regs16), 128'(0));

    // Mode 0 single write, strobe latency and read-back
    spi_write(8'h83, 1, 32'hA5, 32'h0);
    chk("w_reg3", 128'(get_reg(0, 3)), 128'(8'hA5));
    chk("w_strobe_cnt", 128'(strobe_cnt), 128'(1));
    chk("w_strobe_lat", 128'(last_strobe_cyc - last_samp_cyc), 128'(4));
    spi_read(8'h03, rd);
    chk("r_data_m0", 128'(rd), 128'(8'hA5));

    // Burst write with wrap
    spi_write(8'h8F, 2, 32'h11, 32'h22);
    chk("burst_reg15", 128'(get_reg(0, 15)), 128'(8'h11));
    chk("burst_reg0", 128'(get_reg(0, 0)), 128'(8'h22));
    chk("burst_strobes", 128'(strobe_cnt), 128'(3));

    // Aborted write after 5 data bits
    s0 = strobe_cnt;
    spi_begin();
    spi_word(8, 32'h82, tmp);
    spi_word(5, 32'h1F, tmp);
    spi_end();
    chk("abort_reg2", 128'(get_reg(0, 2)), 128'(0));
    chk("abort_no_strobe", 128'(strobe_cnt), 128'(s0));

    // Plain local write lands one cycle later, with no strobe
    laddr = 4'd7; ldata = 16'h0077;
    lw_at_cyc = cyc + 1;
    repeat (2) @(negedge clk);
    chk("local_reg7", 128'(get_reg(0, 7)), 128'(8'h77));
    chk("local_no_strobe", 128'(strobe_cnt), 128'(s0));

    // Same-cycle local/SPI write to the same address: SPI wins
    laddr = 4'd1; ldata = 16'h0055; lw_arm = 1'b1;
    spi_write(8'h81, 1, 32'h66, 32'h0);
    chk("collide_reg1", 128'(get_reg(0, 1)), 128'(8'h66));

    // Same cycle, different addresses: both land
    laddr = 4'd5; ldata = 16'h0055; lw_arm = 1'b1;
    spi_write(8'h81, 1, 32'h66, 32'h0);
    chk("split_reg5", 128'(get_reg(0, 5)), 128'(8'h55));
    chk("split_reg1", 128'(get_reg(0, 1)), 128'(8'h66));

    // Other modes and the 16-bit configuration
    for (int m = 1; m < 5; m++) begin
      cur = m;
      repeat (10) @(negedge clk);
      tmp = (m == 4) ? 32'hA5C3 : 32'hA5;
      spi_write(8'h83, 1, tmp, 32'h0);
      chk("mode_w_reg3", 128'(get_reg(m, 3)), 128'(tmp));
      spi_read(8'h03, rd);
      chk("mode_r_data", 128'(rd), 128'(tmp));
    end
    spi_write(8'h83, 2, 32'h1111, 32'h2222);
    chk("dw16_reg3", 128'(get_reg(4, 3)), 128'(16'h1111));
    chk("dw16_reg0", 128'(get_reg(4, 0)), 128'(16'h2222));

    // Reset in the middle of a burst write
    cur = 0;
    repeat (10) @(negedge clk);
    sb_q.push_back('{0, 0, 32'h5A});
    spi_begin();
    spi_word(8, 32'h80, tmp);
    spi_word(8, 32'h5A, tmp);
    spi_word(4, 32'h3, tmp);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_regs", regs8[0], 128'(0));
    chk("mid_rst_strobe", 128'(strobe8[0]), 128'(0));
    chk("mid_rst_waddr", 128'(waddr8[0]), 128'(0));
    chk("mid_rst_poci", 128'(poci8[0]), 128'(0));
    chk("mid_rst_oe", 128'(oe8[0]), 128'(0));
    @(negedge clk);
    cs_b = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_regs", regs8[0], 128'(0));
    chk("post_rst_oe", 128'(oe8[0]), 128'(0));

    chk("sb_empty", 128'(sb_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/spi_register_bank.md
# spi_register_bank

Parametrised SPI target with an internal register file, oversampled entirely in the `sys_clock_i` domain. It generalises the fixed SPI peripheral inside the top-level user macro:
- configurable data width and register depth;
- all four SPI modes;
- burst auto-increment addressing;
- a local-side write port for status updates.

It sits between the `io_in`/`io_out` SPI pads and the core logic, which consumes the parallel register outputs.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: register and SPI data word width; legal range 8–32.
- `ADDR_WIDTH`, default 4: register count is `DEPTH = 2**ADDR_WIDTH`; legal range 1–7.
- `SPI_MODE`, default 0: bit 1 = CPOL, bit 0 = CPHA.

Ports:
- `sys_clock_i`  in  1  sole clock; all logic is on its rising edge.
- `sys_reset_ni`  in  1  asynchronous, active-low reset.
- `spi_clock_i`  in  1  SPI clock from the pad; asynchronous.
- `spi_cs_i`  in  1  chip select from the pad, active-low; asynchronous.
- `spi_pico_i`  in  1  controller-to-peripheral data; asynchronous.
- `spi_poci_o`  out  1  peripheral-to-controller data.
- `spi_poci_oe_o`  out  1  pad output enable; high while the synchronised CS is asserted.
- `local_we_i`  in  1  local write enable.
- `local_addr_i`  in  `ADDR_WIDTH`  local write address.
- `local_data_i`  in  `DATA_WIDTH`  local write data.
- `regs_o`  out  `DEPTH*DATA_WIDTH`  flattened register file; register n occupies bits `[n*DATA_WIDTH +: DATA_WIDTH]`.
- `spi_write_strobe_o`  out  1  one-cycle pulse per committed SPI write.
- `spi_write_addr_o`  out  `ADDR_WIDTH`  address of the SPI write being committed; valid with the strobe.

## Operation
Input capture:
- `spi_clock_i`, `spi_cs_i` and `spi_pico_i` each pass through a 2-flop synchroniser, followed by a third flop for edge detection.
- The sample edge is the rising edge when CPOL = CPHA, otherwise the falling edge. The shift edge is the opposite edge.
- The synchronised CS falling edge starts a transaction.

Transaction format:
- First 8 bits (command), MSB first: bit 7 = 1 write / 0 read; bits [6:0] = address. Only the low `ADDR_WIDTH` bits are used; upper bits are ignored.
- Then any number of `DATA_WIDTH`-bit words, MSB first, each sampled on sample edges.

States: IDLE, CMD, DATA.
- IDLE → CMD on CS assert; the bit counter clears.
- CMD → DATA on the 8th sample edge. The address register loads at this point.
- On a read command, the shift-out register loads `regs[addr]` at the same sample edge.
- Any state → IDLE on CS deassert.

Write words:
- When the `DATA_WIDTH`-th bit of a word is sampled, the word is committed to `regs[addr]`.
- `spi_write_strobe_o` pulses and `spi_write_addr_o` = addr.
- addr then increments modulo DEPTH.

Read words:
- At each word boundary, the shift-out register reloads from `regs[addr+1]` and addr increments modulo DEPTH.
- Read data is a snapshot taken at load time; later writes do not alter a word already in flight.

Output drive:
- `spi_poci_o` updates only on shift edges: MSB of the shift-out register, then left-shift.
- It is 0 during CMD, during write commands, and in IDLE.

Boundary rules:
- CS deassert mid-word: the partial word is discarded, there is no commit and no strobe. Completed words stay committed.
- CS deassert during CMD: no effect on registers.
- A local write in the same cycle as an SPI commit to the same address: the SPI data wins. To different addresses: both take effect.
- Local writes never pulse `spi_write_strobe_o`.
- Address wrap: after `DEPTH-1`, the next address is 0.
- Reset mid-transaction: immediate return to IDLE and all registers cleared. The controller must reassert CS to start a new transaction.

## Timing
Reset values:
- `regs_o` = 0, `spi_poci_o` = 0, `spi_poci_oe_o` = 0, `spi_write_strobe_o` = 0, `spi_write_addr_o` = 0, state = IDLE.

Latencies, counted from a pad edge first captured at `sys_clock_i` edge k:
- Edge detected at edge k+2.
- Registered effect (commit, `regs_o`, strobe, `spi_poci_o` update, `spi_poci_oe_o`) at edge k+3.
- A local write appears on `regs_o` 1 cycle after `local_we_i`.

SPI clock constraints:
- Each SPI clock phase must be at least 6 `sys_clock_i` periods.
- CS setup to first edge and hold after last edge must each be at least 6 `sys_clock_i` periods.
- Under these constraints, `spi_poci_o` is stable at least 2 cycles before the controller samples it.

## Test plan
- Mode 0, DW=8, AW=4. Write command 0x83, data 0xA5 → `regs[3]` = 0xA5; a single strobe with addr 3, 3 cycles after the 16th rising edge.
- Read command 0x03 after the above → `spi_poci_o` shifts 1010_0101 on falling edges; `spi_poci_oe_o` is high only while CS is low.
- Burst write from address 0x8F, data 0x11, 0x22 → `regs[15]` = 0x11 and `regs[0]` = 0x22 (wrap); two strobes.
- CS deasserted after 5 data bits of a write to addr 2 → `regs[2]` unchanged; no strobe.
- Same-cycle local write 0x55 and SPI commit 0x66, both to addr 1 → `regs[1]` = 0x66. A local write to addr 5 in the same cycle lands 0x55 there.
- Repeat the write and read tests for SPI_MODE 1, 2 and 3, and for DW=16, AW=2 → identical data results. Assert `sys_reset_ni` mid-burst → all outputs return to their reset values immediately.
